// File: rtl/setting_core_pkg.sv
// Shared constants and types for the note-button remapping core.
package setting_core_pkg;

    localparam int unsigned NUM_KEYS = 8;
    localparam int unsigned IDX_W    = 3;

    // Entry K holds the physical button index assigned to logical note K.
    typedef logic [NUM_KEYS-1:0][IDX_W-1:0] key_map_t;

    // In-progress session map; the eighth entry is never stored because the
    // eighth press commits directly.
    typedef logic [NUM_KEYS-2:0][IDX_W-1:0] work_map_t;

    localparam key_map_t IDENTITY_MAP = {
        3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
    };

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_KEYS - 1);

endpackage

// File: rtl/setting_core_onehot_enc.sv
// One-hot to binary encoder; valid_c only when exactly one input bit is set.
module onehot_enc
    import setting_core_pkg::*;
(
    input  logic [NUM_KEYS-1:0] vec,
    output logic [IDX_W-1:0]    idx_c,
    output logic                valid_c
);

    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (vec[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign valid_c = (vec != '0) && ((vec & (vec - NUM_KEYS'(1))) == '0);

endmodule

// File: rtl/setting_core.sv
// Button-to-note remapping: records a press session into a working map and
// commits it atomically on the eighth distinct button.
module setting_core
    import setting_core_pkg::*;
(
    input  logic                slow_clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] pose_buts,
    input  logic                pose_esc,
    output logic [IDX_W-1:0]    perm0,
    output logic [IDX_W-1:0]    perm1,
    output logic [IDX_W-1:0]    perm2,
    output logic [IDX_W-1:0]    perm3,
    output logic [IDX_W-1:0]    perm4,
    output logic [IDX_W-1:0]    perm5,
    output logic [IDX_W-1:0]    perm6,
    output logic [IDX_W-1:0]    perm7,
    output logic [IDX_W-1:0]    setting_cnt
);

    key_map_t            commit_q, commit_d;
    work_map_t           work_q,   work_d;
    logic [NUM_KEYS-1:0] used_q,   used_d;
    logic [IDX_W-1:0]    cnt_q,    cnt_d;

    logic [IDX_W-1:0]    key_idx_c;
    logic                key_onehot_c;
    logic                press_ok_c;

    onehot_enc u_enc (
        .vec     (pose_buts),
        .idx_c   (key_idx_c),
        .valid_c (key_onehot_c)
    );

    // Already-used buttons are rejected so the committed map stays a permutation.
    assign press_ok_c = !pose_esc && key_onehot_c && !used_q[key_idx_c];

    always_comb begin
        commit_d = commit_q;
        work_d   = work_q;
        used_d   = used_q;
        cnt_d    = cnt_q;

        if (pose_esc) begin
            work_d = '0;
            used_d = '0;
            cnt_d  = '0;
        end else if (press_ok_c) begin
            if (cnt_q == LAST_SLOT) begin
                commit_d = {key_idx_c, work_q};
                work_d   = '0;
                used_d   = '0;
                cnt_d    = '0;
            end else begin
                work_d[cnt_q]     = key_idx_c;
                used_d[key_idx_c] = 1'b1;
                cnt_d             = cnt_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge slow_clk) begin
        if (rst_n) begin
            commit_q <= IDENTITY_MAP;
            work_q   <= '0;
            used_q   <= '0;
            cnt_q    <= '0;
        end else begin
            commit_q <= commit_d;
            work_q   <= work_d;
            used_q   <= used_d;
            cnt_q    <= cnt_d;
        end
    end

    assign perm0       = commit_q[0];
    assign perm1       = commit_q[1];
    assign perm2       = commit_q[2];
    assign perm3       = commit_q[3];
    assign perm4       = commit_q[4];
    assign perm5       = commit_q[5];
    assign perm6       = commit_q[6];
    assign perm7       = commit_q[7];
    assign setting_cnt = cnt_q;

endmodule

// File: tb/tb_setting_core.sv
// Directed bench for setting_core: session fill, commit, duplicate/multi-hot
// rejection, escape abort and mid-session reset.
module tb_setting_core;

    logic       slow_clk = 1'b0;
    logic       rst_n;
    logic [7:0] pose_buts;
    logic       pose_esc;
    logic [2:0] perm0, perm1, perm2, perm3, perm4, perm5, perm6, perm7;
    logic [2:0] setting_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    setting_core dut (
        .slow_clk    (slow_clk),
        .rst_n       (rst_n),
        .pose_buts   (pose_buts),
        .pose_esc    (pose_esc),
        .perm0       (perm0),
        .perm1       (perm1),
        .perm2       (perm2),
        .perm3       (perm3),
        .perm4       (perm4),
        .perm5       (perm5),
        .perm6       (perm6),
        .perm7       (perm7),
        .setting_cnt (setting_cnt)
    );

    always #5 slow_clk = ~slow_clk;

    localparam logic [23:0] MAP_ID  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [23:0] MAP_REV = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    // Session 3,5,0,1,2,4,6,7 -> perm0=3, perm1=5, perm2=0, ..., perm7=7.
    localparam logic [23:0] MAP_MIX = {3'd7, 3'd6, 3'd4, 3'd2, 3'd1, 3'd0, 3'd5, 3'd3};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input; returns 1 time unit after the capturing edge.
    task automatic press(input logic [7:0] b, input logic e);
        @(negedge slow_clk);
        pose_buts = b;
        pose_esc  = e;
        @(posedge slow_clk);
        #1;
        pose_buts = '0;
        pose_esc  = 1'b0;
    endtask

    task automatic press_idx(input int b);
        logic [7:0] v;
        v = 8'd1 << b;
        press(v, 1'b0);
    endtask

    function automatic logic [31:0] perms();
        return {8'd0, perm7, perm6, perm5, perm4, perm3, perm2, perm1, perm0};
    endfunction

    initial begin
        int seq3 [6];
        seq3 = '{0, 1, 2, 4, 6, 7};

        rst_n     = 1'b1;
        pose_buts = '0;
        pose_esc  = 1'b0;
        repeat (2) @(posedge slow_clk);
        #1;
        check_eq("reset_cnt", 32'(setting_cnt), 32'd0);
        check_eq("reset_perm", perms(), 32'(MAP_ID));
        @(negedge slow_clk);
        rst_n = 1'b0;

        // Ascending session: count 1..7 then wrap to 0 on commit.
        for (int i = 0; i < 8; i++) begin
            press_idx(i);
            check_eq($sformatf("asc_cnt%0d", i), 32'(setting_cnt), 32'((i + 1) % 8));
            if (i == 6) check_eq("asc_pre_commit", perms(), 32'(MAP_ID));
        end
        check_eq("asc_perm", perms(), 32'(MAP_ID));

        // Descending session produces the reversed map only on the eighth press.
        for (int i = 7; i >= 0; i--) begin
            press_idx(i);
            if (i == 1) check_eq("rev_pre_commit", perms(), 32'(MAP_ID));
        end
        check_eq("rev_cnt", 32'(setting_cnt), 32'd0);
        check_eq("rev_perm", perms(), 32'(MAP_REV));

        // Duplicate press is ignored; working order observed through the commit.
        press_idx(3);
        check_eq("dup_cnt1", 32'(setting_cnt), 32'd1);
        press_idx(3);
        check_eq("dup_cnt_same", 32'(setting_cnt), 32'd1);
        press_idx(5);
        check_eq("dup_cnt2", 32'(setting_cnt), 32'd2);
        check_eq("dup_perm_hold", perms(), 32'(MAP_REV));
        for (int i = 0; i < 6; i++) press_idx(seq3[i]);
        check_eq("mix_cnt", 32'(setting_cnt), 32'd0);
        check_eq("mix_perm", perms(), 32'(MAP_MIX));

        // Escape with a simultaneous button aborts and does not record it.
        press_idx(2);
        press_idx(4);
        check_eq("esc_pre_cnt", 32'(setting_cnt), 32'd2);
        press(8'b0100_0000, 1'b1);
        check_eq("esc_cnt", 32'(setting_cnt), 32'd0);
        check_eq("esc_perm", perms(), 32'(MAP_MIX));
        press_idx(2);
        check_eq("esc_used_clear", 32'(setting_cnt), 32'd1);
        press_idx(6);
        check_eq("esc_bit6_free", 32'(setting_cnt), 32'd2);
        press(8'h00, 1'b1);
        press(8'h00, 1'b1);
        check_eq("esc_idle_cnt", 32'(setting_cnt), 32'd0);
        check_eq("esc_idle_perm", perms(), 32'(MAP_MIX));

        // Zero and multi-hot patterns are ignored.
        press(8'b0000_0110, 1'b0);
        check_eq("multi_cnt", 32'(setting_cnt), 32'd0);
        press(8'hff, 1'b0);
        check_eq("allhot_cnt", 32'(setting_cnt), 32'd0);
        press(8'h00, 1'b0);
        check_eq("zero_cnt", 32'(setting_cnt), 32'd0);

        // Reset mid-session overrides a same-cycle press and restores identity.
        for (int i = 0; i < 5; i++) press_idx(i);
        check_eq("mid_cnt5", 32'(setting_cnt), 32'd5);
        @(negedge slow_clk);
        rst_n     = 1'b1;
        pose_buts = 8'h80;
        @(posedge slow_clk);
        #1;
        rst_n     = 1'b0;
        pose_buts = '0;
        check_eq("rst_cnt", 32'(setting_cnt), 32'd0);
        check_eq("rst_perm", perms(), 32'(MAP_ID));
        press_idx(0);
        check_eq("rst_used_clear", 32'(setting_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
